// File: rtl/arch_defs_pkg.sv
// Architecture-wide definitions shared by the SAP-2 computer blocks.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick for one cycle at terminal count.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Decoded from the registered count, so the tick is clean and clear always wins.
  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// 8N1 UART transmitter, LSB first, line idles high; optional forced-low stop bit
// lets a receiver's frame-error path be exercised.
module uart_tx_frame_gen
  import arch_defs_pkg::*;
#(
  parameter int CLOCK_SPEED = 2_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_parallel_data_in,
  input  logic                  tx_strobe_start,
  input  logic                  tx_force_frame_error,
  output logic                  tx_strobe_busy,
  output logic                  tx_serial_data_out,
  output logic [1:0]            tx_state_dbg
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int IDX_W        = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_frame_gen: CLOCK_SPEED / BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [IDX_W-1:0]        bit_idx;
  logic                    err_q;
  logic                    baud_tick;

  assign tx_state_dbg = state;

  // The counter is held at zero while idle, so the accepting edge starts a full bit period.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .enable(1'b1),
    .tick  (baud_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      shift_q            <= '0;
      bit_idx            <= '0;
      err_q              <= 1'b0;
      tx_serial_data_out <= 1'b1;
      tx_strobe_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_strobe_start) begin
            shift_q            <= tx_parallel_data_in;
            err_q              <= tx_force_frame_error;
            tx_serial_data_out <= 1'b0;
            tx_strobe_busy     <= 1'b1;
            state              <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx_serial_data_out <= shift_q[0];
            shift_q            <= shift_q >> 1;
            bit_idx            <= '0;
            state              <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx == LAST_BIT) begin
              tx_serial_data_out <= ~err_q;
              state              <= STOP;
            end else begin
              tx_serial_data_out <= shift_q[0];
              shift_q            <= shift_q >> 1;
              bit_idx            <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          // A strobe arriving on this edge is ignored; it is taken on the next idle edge.
          if (baud_tick) begin
            tx_serial_data_out <= 1'b1;
            tx_strobe_busy     <= 1'b0;
            err_q              <= 1'b0;
            state              <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen at default parameters (208 clocks per bit).
module tb_uart_tx_frame_gen;

  logic       clk;
  logic       reset;
  logic [7:0] tx_parallel_data_in;
  logic       tx_strobe_start;
  logic       tx_force_frame_error;
  logic       tx_strobe_busy;
  logic       tx_serial_data_out;
  logic [1:0] tx_state_dbg;

  int checks   = 0;
  int failures = 0;

  uart_tx_frame_gen dut (
    .clk                 (clk),
    .reset               (reset),
    .tx_parallel_data_in (tx_parallel_data_in),
    .tx_strobe_start     (tx_strobe_start),
    .tx_force_frame_error(tx_force_frame_error),
    .tx_strobe_busy      (tx_strobe_busy),
    .tx_serial_data_out  (tx_serial_data_out),
    .tx_state_dbg        (tx_state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: raise the strobe on a falling edge, drop it on the next one.
  task automatic strobe_frame(input logic [7:0] data, input logic err);
    tx_parallel_data_in  = data;
    tx_force_frame_error = err;
    tx_strobe_start      = 1'b1;
    @(negedge clk);
    tx_strobe_start      = 1'b0;
  endtask

  // Called on the falling edge just after the accepting edge (c = 0).
  // Samples the line at bit centres, counts busy cycles, optionally fires a
  // strobe (with different data/error) mid-frame. Returns on the first idle sample.
  task automatic run_frame(input string tag, input logic [9:0] exp_bits,
                           input int inject_at, input logic [7:0] inject_data);
    int busy_cnt;
    int c;
    int k;
    busy_cnt = 0;
    c = 0;
    while (c < 2300 && tx_strobe_busy === 1'b1) begin
      busy_cnt++;
      if (c >= 104 && ((c - 104) % 208) == 0) begin
        k = (c - 104) / 208;
        if (k < 10) check($sformatf("%s_bit%0d", tag, k), 32'(tx_serial_data_out), 32'(exp_bits[k]));
      end
      if (c == inject_at) begin
        tx_parallel_data_in  = inject_data;
        tx_force_frame_error = 1'b1;
        tx_strobe_start      = 1'b1;
      end else if (c == inject_at + 1) begin
        tx_strobe_start      = 1'b0;
        tx_force_frame_error = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd2080);
    check({tag, "_idle_line"}, 32'(tx_serial_data_out), 32'd1);
  endtask

  // Watches for n cycles that nothing leaves idle.
  task automatic idle_watch(input string tag, input int n);
    int active;
    active = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_strobe_busy !== 1'b0 || tx_serial_data_out !== 1'b1) active++;
    end
    check(tag, 32'(active), 32'd0);
  endtask

  initial begin
    reset                = 1'b0;
    tx_parallel_data_in  = 8'h00;
    tx_strobe_start      = 1'b0;
    tx_force_frame_error = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_line", 32'(tx_serial_data_out), 32'd1);
    check("rst_busy", 32'(tx_strobe_busy), 32'd0);
    check("rst_state", 32'(tx_state_dbg), 32'd0);
    reset = 1'b1;
    idle_watch("post_reset_idle", 500);

    // 0xDD, normal stop: 0 | 1 0 1 1 1 0 1 1 | 1
    strobe_frame(8'hDD, 1'b0);
    check("dd_start_line", 32'(tx_serial_data_out), 32'd0);
    run_frame("dd", 10'b1110111010, -1, 8'h00);
    idle_watch("dd_gap", 20);

    // 0xDD, forced bad stop bit
    strobe_frame(8'hDD, 1'b1);
    run_frame("dd_err", 10'b0110111010, -1, 8'h00);
    idle_watch("dd_err_gap", 20);

    // 0x55, then 0xAA (with error set) while busy: ignored
    strobe_frame(8'h55, 1'b0);
    run_frame("x55", 10'b1010101010, 500, 8'hAA);
    idle_watch("x55_no_second", 2500);

    // Back-to-back: 0xFF strobed on the first idle cycle after 0x00
    strobe_frame(8'h00, 1'b0);
    run_frame("x00", 10'b1000000000, -1, 8'h00);
    strobe_frame(8'hFF, 1'b0);
    check("b2b_start_busy", 32'(tx_strobe_busy), 32'd1);
    check("b2b_start_line", 32'(tx_serial_data_out), 32'd0);
    run_frame("xff", 10'b1111111110, -1, 8'h00);
    idle_watch("xff_gap", 20);

    // Reset mid-frame at cycle 700 of 0x3C
    strobe_frame(8'h3C, 1'b0);
    repeat (700) @(negedge clk);
    check("mid_busy_before", 32'(tx_strobe_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_line", 32'(tx_serial_data_out), 32'd1);
    check("mid_rst_busy", 32'(tx_strobe_busy), 32'd0);
    check("mid_rst_state", 32'(tx_state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_watch("mid_rst_idle", 10);

    // 0xA5 after the abandoned frame: 0 | 1 0 1 0 0 1 0 1 | 1
    strobe_frame(8'hA5, 1'b0);
    run_frame("xa5", 10'b1101001010, -1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
- Serial UART transmitter for the 8-bit SAP-2 computer: 8N1 framing, LSB first, line idles high.
- Used inside the computer's UART block and as the stimulus generator in computer-level benches.
- Extra input forces a bad (low) stop bit so the receiver's frame-error path can be exercised.

Parameters:
- CLOCK_SPEED, 2_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in bits/s.
- Derived constant CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE, integer division (208 at defaults). Elaboration error if result < 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_parallel_data_in  input  DATA_WIDTH(8)  byte to send; sampled only on an accepted start strobe.
- tx_strobe_start  input  1  one-cycle request to start a frame.
- tx_force_frame_error  input  1  sampled with the start strobe; 1 = send stop bit as 0.
- tx_strobe_busy  output  1  high while a frame is in progress.
- tx_serial_data_out  output  1  serial line; idle = 1.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, tx_serial_data_out=1, tx_strobe_busy=0, shift register, bit index, baud counter and error flag cleared. Released on first rising edge with reset=1.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - line=1, busy=0.
  - On rising edge with tx_strobe_start=1: latch data byte and tx_force_frame_error, clear baud counter, go to START.
  - busy=1 and line=0 from that edge onward.
- START: line=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - line = latched_data[bit_index] for CLKS_PER_BIT cycles each.
  - Bits sent LSB first, index 0..7; after bit 7 go to STOP.
- STOP:
  - line = 1, or 0 if the latched force-error flag is set, for CLKS_PER_BIT cycles.
  - Then IDLE: line=1, busy=0.
- Frame length: exactly 10*CLKS_PER_BIT cycles from accepting edge to the busy-falling edge (2080 at defaults).
- Baud counter runs 0..CLKS_PER_BIT-1; a bit boundary occurs at terminal count.
- tx_serial_data_out and tx_strobe_busy are registered outputs, glitch-free.
- tx_strobe_start while busy is ignored; no queueing. Data and error inputs may change freely mid-frame with no effect.
- Start strobe in the same cycle the STOP bit completes is ignored; it is accepted on the next cycle in IDLE.
- Holding tx_strobe_start high continuously gives back-to-back frames with one idle-high cycle between them.
- Reset asserted mid-frame: immediate line=1, busy=0, frame abandoned.
- Force-error flag applies only to the frame it was latched with.

Decomposition:
- DATA_WIDTH comes from the shared arch_defs_pkg.
- State enum (IDLE/START/DATA/STOP) stays local to the module; no package entry.
- One optional sub-module: uart_baud_counter (parameter CLKS_PER_BIT; inputs clear/enable; output one-cycle tick at terminal count), reusable by the receiver.
- Otherwise a single flat module.

Test Plan:
- Reset: hold reset=0 for 5 cycles -> line=1, busy=0; no activity for 500 cycles after release without a strobe.
- Send 0xDD, force_error=0:
  - Line samples at bit centres (start+104+208k cycles) = 0,1,0,1,1,1,0,1,1,1 (start, LSB-first data, stop).
  - busy high exactly 2080 cycles.
- Send 0xDD, force_error=1: same start and data bits, stop-bit sample = 0, busy drops after 2080 cycles, line returns to 1.
- Strobe 0x55 then strobe 0xAA 500 cycles later while busy -> only 0x55 transmitted (0,1,0,1,0,1,0,1,0,1); no second frame follows.
- Back-to-back: strobe 0x00, then strobe 0xFF on the first idle cycle -> second frame starts one cycle after busy falls and carries data bits all 1.
- Reset mid-frame at cycle 700 of a 0x3C frame -> line=1 and busy=0 immediately; next strobe of 0xA5 is transmitted correctly.
